// File: rtl/mem_hs_ram_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the handshaked byte-addressable RAM (mem_hs_ram) and
// its lane-alignment helper (mem_lane_align).
//   - size_t  : access size codes driven on Size
//   - state_t : request FSM states (IDLE / WAIT / ACK)
//   - CNT_W   : width of the latency wait counter (LATENCY range 0..15)
//   - is_misaligned() : alignment rule used by the optional address trap
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11   // behaves exactly like SZ_WORD
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } state_t;

  // Halfwords must sit on even addresses, words (and the reserved code) on
  // multiples of four. Bytes are always aligned.
  function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_hs_ram_if.sv
// -----------------------------------------------------------------------------
// mem_hs_ram_if
// Request/response bus between the datapath/control unit (master) and the RAM
// (slave).
//   MOV      master->slave  request valid
//   RW       master->slave  1 = read, 0 = write
//   Size     master->slave  access size code (mem_pkg::size_t)
//   SignExt  master->slave  read extension: 1 = sign, 0 = zero
//   Address  master->slave  byte address
//   DataIn   master->slave  right-justified write data
//   DataOut  slave->master  registered read data
//   MOC      slave->master  memory operation complete
//   AddrErr  slave->master  misaligned access flag (only with MISALIGN_TRAP_EN)
//
// Handshake: the master raises MOV with the request fields valid; the slave
// samples them on the first edge it is idle and MOV=1, then ignores the bus.
// MOC rises when the access has committed and stays high until the master
// drops MOV; MOC falls on the edge that samples MOV=0. The master may present
// a new request only after it has observed MOC low again.
// -----------------------------------------------------------------------------
interface mem_hs_ram_if;

  logic        MOV;
  logic        RW;
  logic [1:0]  Size;
  logic        SignExt;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;
`ifdef MISALIGN_TRAP_EN
  logic        AddrErr;
`endif

  modport master (
    output MOV,
    output RW,
    output Size,
    output SignExt,
    output Address,
    output DataIn,
    input  DataOut,
`ifdef MISALIGN_TRAP_EN
    input  AddrErr,
`endif
    input  MOC
  );

  modport slave (
    input  MOV,
    input  RW,
    input  Size,
    input  SignExt,
    input  Address,
    input  DataIn,
    output DataOut,
`ifdef MISALIGN_TRAP_EN
    output AddrErr,
`endif
    output MOC
  );

endinterface

// File: rtl/mem_hs_ram_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational big-endian lane steering for byte/halfword/word accesses.
// Lane 0 is bits [31:24] and holds the byte at the word-aligned base address,
// lane 3 is bits [7:0] and holds base+3.
//   i_size     access size (SZ_RSVD behaves as SZ_WORD)
//   i_addr_lo  low two address bits; halfwords ignore bit 0, words ignore both
//   i_sext     read extension: 1 = sign, 0 = zero
//   i_wdata    right-justified write data
//   i_rword    the 32-bit word currently stored at the aligned base address
//   o_be       per-lane write enables, bit i enables lane i
//   o_wdata    write data replicated so each enabled lane sees its bytes
//   o_rdata    selected read data, extended to 32 bits
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_pkg::*;
(
  input  size_t       i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_sext,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    o_rdata = i_rword;
    w_byte  = 8'h00;
    w_half  = 16'h0000;

    case (i_size)
      SZ_BYTE: begin
        // Replicating the byte lets the enable alone pick the lane.
        o_wdata = {4{i_wdata[7:0]}};
        case (i_addr_lo)
          2'd0:    begin o_be = 4'b0001; w_byte = i_rword[31:24]; end
          2'd1:    begin o_be = 4'b0010; w_byte = i_rword[23:16]; end
          2'd2:    begin o_be = 4'b0100; w_byte = i_rword[15:8];  end
          default: begin o_be = 4'b1000; w_byte = i_rword[7:0];   end
        endcase
        o_rdata = {{24{i_sext & w_byte[7]}}, w_byte};
      end

      SZ_HALF: begin
        o_wdata = {2{i_wdata[15:0]}};
        if (i_addr_lo[1]) begin
          o_be   = 4'b1100;
          w_half = i_rword[15:0];
        end else begin
          o_be   = 4'b0011;
          w_half = i_rword[31:16];
        end
        o_rdata = {{16{i_sext & w_half[15]}}, w_half};
      end

      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
    endcase
  end

endmodule

// File: rtl/mem_hs_ram.sv
// -----------------------------------------------------------------------------
// mem_hs_ram
// Byte-addressable big-endian instruction/data RAM with a MOV/MOC completion
// handshake and a programmable access latency, sitting behind the datapath's
// MAR/DataIn/RW/MOV outputs.
//
// Parameters
//   ADDR_W   byte address bits used; depth = 2**ADDR_W bytes (>= 3)
//   LATENCY  wait cycles between request capture and commit (0..15)
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   bus          mem_hs_ram_if.slave (MOV/RW/Size/SignExt/Address/DataIn in,
//                DataOut/MOC out, AddrErr out with MISALIGN_TRAP_EN)
//   o_dbg_state  current request FSM state
//
// Configuration
//   MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses complete
//                     with AddrErr=1, DataOut=0 and no array write. When
//                     undefined, the offending low address bits are ignored.
//
// Timing: MOV first sampled high at edge k -> MOC rises at edge k+LATENCY+1.
// The array is not cleared by reset; a reset during WAIT drops the request.
// -----------------------------------------------------------------------------
module mem_hs_ram
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_hs_ram_if.slave    bus,
  output state_t         o_dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage: one byte per entry, contents survive reset.
  logic [7:0]        r_mem [DEPTH];

  // FSM and handshake registers
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_moc;
  logic [31:0]       r_dout;

  // Request captured in IDLE; the bus is ignored until the next IDLE
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  size_t             r_size;
  logic              r_sext;
  logic [31:0]       r_din;

  // Next-state signals
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_moc_nxt;
  logic [31:0]       w_dout_nxt;
  logic              w_capture;
  logic              w_mem_we;

  // Lane steering
  logic [ADDR_W-1:0] w_base;
  logic [31:0]       w_rword;
  logic [3:0]        w_be;
  logic [31:0]       w_lane_wdata;
  logic [31:0]       w_lane_rdata;
  logic              w_trap;

  // Address bits above ADDR_W wrap away by design.
  logic              w_unused_addr_hi;
  assign w_unused_addr_hi = ^bus.Address[31:ADDR_W];

`ifdef MISALIGN_TRAP_EN
  logic              r_addr_err;
  logic              w_err_nxt;
  assign w_trap      = is_misaligned(r_size, r_addr[1:0]);
  assign bus.AddrErr = r_addr_err;
`else
  assign w_trap      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Word-aligned view of the array around the captured address. The base is
  // aligned, so OR-ing the lane number is the same as adding it and can
  // never leave the array.
  // ---------------------------------------------------------------------------
  assign w_base  = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_rword = {r_mem[w_base],
                    r_mem[w_base | ADDR_W'(1)],
                    r_mem[w_base | ADDR_W'(2)],
                    r_mem[w_base | ADDR_W'(3)]};

  mem_lane_align u_lane_align (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .i_sext    (r_sext),
    .i_wdata   (r_din),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_lane_wdata),
    .o_rdata   (w_lane_rdata)
  );

  // ---------------------------------------------------------------------------
  // Request FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_moc_nxt   = r_moc;
    w_dout_nxt  = r_dout;
    w_capture   = 1'b0;
    w_mem_we    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    w_err_nxt   = r_addr_err;
`endif

    case (r_state)
      ST_IDLE: begin
        if (bus.MOV) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = CNT_W'(LATENCY);
          w_state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // MOV is not looked at here: a request, once captured, always runs.
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_moc_nxt   = 1'b1;
          w_state_nxt = ST_ACK;
          if (w_trap) begin
            w_dout_nxt = '0;
`ifdef MISALIGN_TRAP_EN
            w_err_nxt  = 1'b1;
`endif
          end else if (r_rw) begin
            w_dout_nxt = w_lane_rdata;
          end else begin
            w_mem_we = 1'b1;
          end
        end
      end

      ST_ACK: begin
        // Returning to IDLE (not capturing) keeps one dead cycle between
        // MOC falling and the next acceptance.
        if (!bus.MOV) begin
          w_moc_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
`ifdef MISALIGN_TRAP_EN
          w_err_nxt   = 1'b0;
`endif
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_moc_nxt   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request FSM: registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_moc      <= 1'b0;
      r_dout     <= '0;
      r_addr     <= '0;
      r_rw       <= 1'b1;
      r_size     <= SZ_BYTE;
      r_sext     <= 1'b0;
      r_din      <= '0;
`ifdef MISALIGN_TRAP_EN
      r_addr_err <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_moc      <= w_moc_nxt;
      r_dout     <= w_dout_nxt;
`ifdef MISALIGN_TRAP_EN
      r_addr_err <= w_err_nxt;
`endif
      if (w_capture) begin
        r_addr <= bus.Address[ADDR_W-1:0];
        r_rw   <= bus.RW;
        r_size <= size_t'(bus.Size);
        r_sext <= bus.SignExt;
        r_din  <= bus.DataIn;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Array write port. Gating with reset makes a reset on the commit edge win
  // over the write, matching the FSM being forced back to IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset && w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_base | ADDR_W'(i)] <= w_lane_wdata[31-8*i -: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.DataOut  = r_dout;
  assign bus.MOC      = r_moc;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_hs_ram.sv
// -----------------------------------------------------------------------------
// tb_mem_hs_ram
// Self-checking bench for mem_hs_ram (default ADDR_W=9, LATENCY=2). A byte
// array reference model computes expected read data straight from the
// big-endian / extension / masking rules; directed steps follow the test plan
// and a randomized phase mixes sizes, extensions, addresses and ACK hold times.
// Builds with or without MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_mem_hs_ram;
  import mem_pkg::*;

  localparam int ADDR_W  = 9;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 1 << ADDR_W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic   clk   = 1'b0;
  logic   reset = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  mem_hs_ram_if bus ();

  mem_hs_ram #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] ref_dout = 32'h0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain byte array, big-endian, modulo-depth addressing
  // ---------------------------------------------------------------------------
  function automatic bit ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
    if (size == 2'b00) return 1'b0;
    if (size == 2'b01) return addr[0];
    return addr[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_read(input logic [1:0] size, input logic sext,
                                           input logic [31:0] addr);
    int unsigned a;
    logic [31:0] v;
    a = addr % DEPTH;
    if (size == 2'b00) begin
      v = {24'h0, ref_mem[a]};
      if (sext && v[7]) v[31:8] = 24'hFFFFFF;
    end else if (size == 2'b01) begin
      a = a & ~32'd1;
      v = {16'h0, ref_mem[a], ref_mem[(a + 1) % DEPTH]};
      if (sext && v[15]) v[31:16] = 16'hFFFF;
    end else begin
      a = a & ~32'd3;
      v = {ref_mem[a], ref_mem[(a + 1) % DEPTH],
           ref_mem[(a + 2) % DEPTH], ref_mem[(a + 3) % DEPTH]};
    end
    return v;
  endfunction

  task automatic ref_write(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] din);
    int unsigned a;
    a = addr % DEPTH;
    if (size == 2'b00) begin
      ref_mem[a] = din[7:0];
    end else if (size == 2'b01) begin
      a = a & ~32'd1;
      ref_mem[a]               = din[15:8];
      ref_mem[(a + 1) % DEPTH] = din[7:0];
    end else begin
      a = a & ~32'd3;
      ref_mem[a]               = din[31:24];
      ref_mem[(a + 1) % DEPTH] = din[23:16];
      ref_mem[(a + 2) % DEPTH] = din[15:8];
      ref_mem[(a + 3) % DEPTH] = din[7:0];
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one complete handshake. Called at posedge+1.
  //   hold  : extra cycles MOV is kept high after MOC is seen
  //   pulse : drop MOV right after the capture edge
  // While the request is in flight the bus fields are scrambled, so any
  // re-sampling of the inputs shows up as a data error.
  // ---------------------------------------------------------------------------
  task automatic access(input string tag, input logic rw, input logic [1:0] size,
                        input logic sext, input logic [31:0] addr, input logic [31:0] din,
                        input int hold, input bit pulse);
    bit trap;
    bit seen;
    int n;
    logic [31:0] exp;

    trap = ref_misaligned(size, addr);
    if (trap)    ref_dout = 32'h0;
    else if (rw) ref_dout = ref_read(size, sext, addr);
    else         ref_write(size, addr, din);
    exp_q.push_back(ref_dout);

    bus.MOV     = 1'b1;
    bus.RW      = rw;
    bus.Size    = size;
    bus.SignExt = sext;
    bus.Address = addr;
    bus.DataIn  = din;

    @(posedge clk); #1;  // capture edge
    check({tag, "_moc_capture"}, {31'h0, bus.MOC}, 32'h0);
    if (pulse) bus.MOV = 1'b0;
    bus.RW      = $urandom_range(0, 1);
    bus.Size    = 2'($urandom_range(0, 3));
    bus.SignExt = $urandom_range(0, 1);
    bus.Address = $urandom;
    bus.DataIn  = $urandom;

    n    = 1;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.MOC === 1'b1) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(n), 32'(LATENCY + 2));

    if (seen) begin
      exp = exp_q.pop_front();
      check({tag, "_dataout"}, bus.DataOut, exp);
`ifdef MISALIGN_TRAP_EN
      check({tag, "_addrerr"}, {31'h0, bus.AddrErr}, {31'h0, trap});
`endif
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check({tag, "_hold_moc"}, {31'h0, bus.MOC}, 32'h1);
        check({tag, "_hold_state"}, 32'(dbg_state), 32'(ST_ACK));
      end
      bus.MOV = 1'b0;
      @(posedge clk); #1;
      check({tag, "_moc_fall"}, {31'h0, bus.MOC}, 32'h0);
      check({tag, "_dataout_keep"}, bus.DataOut, exp);
`ifdef MISALIGN_TRAP_EN
      check({tag, "_addrerr_fall"}, {31'h0, bus.AddrErr}, 32'h0);
`endif
    end else begin
      bus.MOV = 1'b0;
      exp_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed + random stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] old_word;

    // Reset held with a write request already pending on the bus.
    reset       = 1'b0;
    bus.MOV     = 1'b1;
    bus.RW      = 1'b0;
    bus.Size    = 2'b10;
    bus.SignExt = 1'b0;
    bus.Address = 32'h0;
    bus.DataIn  = 32'hCAFEF00D;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_moc", {31'h0, bus.MOC}, 32'h0);
      check("rst_dataout", bus.DataOut, 32'h0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
`ifdef MISALIGN_TRAP_EN
      check("rst_addrerr", {31'h0, bus.AddrErr}, 32'h0);
`endif
    end
    reset = 1'b1;
    // First acceptance happens on the first edge after release.
    access("first_req", 1'b0, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 0, 1'b0);

    // Give every word a known value.
    for (int w = 1; w < DEPTH / 4; w++) begin
      access("init", 1'b0, 2'b10, 1'b0, 32'(w * 4), $urandom, 0, 1'b0);
    end

    // Word, byte and halfword directed values.
    access("wr_w4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h12345678, 0, 1'b0);
    access("rd_w4", 1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 0, 1'b0);
    check("rd_w4_value", bus.DataOut, 32'h12345678);
    access("rd_b5", 1'b1, 2'b00, 1'b0, 32'h5, 32'h0, 0, 1'b0);
    check("rd_b5_value", bus.DataOut, 32'h00000034);
    access("wr_b6", 1'b0, 2'b00, 1'b0, 32'h6, 32'hFFFFFF80, 0, 1'b0);
    access("rd_b6_sext", 1'b1, 2'b00, 1'b1, 32'h6, 32'h0, 0, 1'b0);
    check("rd_b6_value", bus.DataOut, 32'hFFFFFF80);
    access("rd_h6", 1'b1, 2'b01, 1'b0, 32'h6, 32'h0, 0, 1'b0);
    check("rd_h6_value", bus.DataOut, 32'h00008078);
    access("rd_h6_sext", 1'b1, 2'b01, 1'b1, 32'h6, 32'h0, 0, 1'b0);
    check("rd_h6_sext_value", bus.DataOut, 32'hFFFF8078);

    // Upper address bits are ignored.
    access("wr_wrap", 1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'hAABBCCDD, 0, 1'b0);
    access("rd_wrap", 1'b1, 2'b10, 1'b0, 32'h000001FC, 32'h0, 0, 1'b0);
    check("rd_wrap_value", bus.DataOut, 32'hAABBCCDD);

    // Long ACK hold, and a one-cycle MOV pulse that must still complete.
    access("hold5", 1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 5, 1'b0);
    access("pulse", 1'b1, 2'b00, 1'b1, 32'h6, 32'h0, 0, 1'b1);
    check("pulse_value", bus.DataOut, 32'hFFFFFF80);

    // Reset in the middle of a write's WAIT: the write must be lost.
    old_word    = ref_read(2'b10, 1'b0, 32'h10);
    bus.MOV     = 1'b1;
    bus.RW      = 1'b0;
    bus.Size    = 2'b10;
    bus.SignExt = 1'b0;
    bus.Address = 32'h10;
    bus.DataIn  = ~old_word;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_state_wait", 32'(dbg_state), 32'(ST_WAIT));
    reset   = 1'b0;
    bus.MOV = 1'b0;
    @(posedge clk); #1;
    check("abort_moc", {31'h0, bus.MOC}, 32'h0);
    check("abort_dataout", bus.DataOut, 32'h0);
    check("abort_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    ref_dout = 32'h0;
    reset    = 1'b1;
    repeat (LATENCY + 3) begin
      @(posedge clk); #1;
      check("abort_no_moc", {31'h0, bus.MOC}, 32'h0);
    end
    access("abort_rd", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    check("abort_rd_value", bus.DataOut, old_word);

    // Misaligned word read: trapped or masked depending on the build.
    access("mis_rd_w2", 1'b1, 2'b10, 1'b0, 32'h2, 32'h0, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    check("mis_rd_w2_value", bus.DataOut, 32'h0);
`else
    check("mis_rd_w2_value", bus.DataOut, ref_read(2'b10, 1'b0, 32'h0));
`endif
    access("mis_wr_h1", 1'b0, 2'b01, 1'b0, 32'h21, 32'h0000BEEF, 0, 1'b0);
    access("mis_rd_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 0, 1'b0);

    // Randomized mix checked against the model.
    for (int i = 0; i < 80; i++) begin
      int  hold;
      bit  pulse;
      hold  = $urandom_range(0, 3);
      pulse = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      access("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom, hold, pulse);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_hs_ram.md
Name: mem_hs_ram

Overview:
- Byte-addressable, big-endian instruction/data memory directly downstream of the datapath's MAR/DataIn/RW/MOV outputs.
- Produces DataOut (consumed by the IR load and the MDR input mux) and the MOC completion handshake consumed by the control unit.
- Access latency is programmable so that the control unit's memory wait states are exercised.
- Supports MIPS byte, halfword and word accesses, with sign or zero extension on reads.

Parameters:
- ADDR_W, 9, byte address bits used; depth = 2^ADDR_W bytes.
- LATENCY, 2, wait cycles between request capture and access commit (0..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- MOV  in  1  memory operation valid (request).
- RW  in  1  1 = read, 0 = write.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- SignExt  in  1  reads only: 1 = sign-extend, 0 = zero-extend.
- Address  in  32  byte address from MAR; only [ADDR_W-1:0] used, upper bits ignored (wrap modulo depth).
- DataIn  in  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
- DataOut  out  32  registered read data.
- MOC  out  1  memory operation complete.
- AddrErr  out  1  present only with MISALIGN_TRAP_EN.

Behaviour:
- Reset (reset==0 at an edge): state IDLE, MOC=0, DataOut=0, AddrErr=0, wait counter=0.
- Memory array contents are not cleared by reset.
- A reset while in WAIT aborts the request; no write commits.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On an edge with MOV=1, capture Address, RW, Size, SignExt and DataIn.
  - Load counter=LATENCY and go to WAIT.
  - MOC stays 0.
- WAIT:
  - If counter != 0, decrement it.
  - If counter == 0, commit the access: write to the array, or register the read result into DataOut.
  - On commit, set MOC=1 and go to ACK.
  - Inputs are ignored in this state; captured values are used.
  - MOV dropping during WAIT does not cancel the request.
- ACK:
  - MOC stays 1 while MOV=1.
  - On the edge where MOV=0, MOC=0 and go to IDLE.
  - A new request is accepted no earlier than the following edge, so there is no back-to-back acceptance in the same cycle MOC falls.
- Latency:
  - If MOV is first sampled high at edge k, MOC rises at edge k+LATENCY+1.
  - With LATENCY=0, MOC rises on the edge after capture.
- Endianness: big-endian. Byte at address A maps to bits [31:24] of the word at A&~3.
- Reads:
  - Word: {m[A], m[A+1], m[A+2], m[A+3]}.
  - Halfword: {m[A], m[A+1]}, extended to 32 bits per SignExt.
  - Byte: m[A], extended to 32 bits per SignExt.
- Writes:
  - Only the addressed bytes change.
  - DataOut keeps its previous value on writes.
- Alignment without the optional feature: address low bits are masked (halfword ignores A[0], word ignores A[1:0]).
- Wrap-around: A+1..A+3 are computed modulo 2^ADDR_W.
- Simultaneous events: reset has priority over MOV.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - AddrErr port exists.
  - A halfword access with A[0]=1, or a word access with A[1:0]!=0, still takes LATENCY+1 cycles and raises MOC with AddrErr=1.
  - The array is unchanged and DataOut=0.
  - AddrErr clears together with MOC.
- Undefined:
  - No AddrErr port.
  - Misaligned addresses are masked as above.

Decomposition:
- Shared package mem_pkg:
  - Size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state encoding for IDLE/WAIT/ACK.
  - LATENCY counter width constant (4).
- Sub-module mem_lane_align, combinational:
  - Builds per-byte write enables and lane-shifted write data from Size/Address/DataIn.
  - Extracts and extends read data.
  - Reused later by the MDR path.

Test Plan:
- Reset with MOV=1 held → MOC=0, DataOut=0 for all cycles in reset; the first request is accepted only after release.
- LATENCY=2: write word 0x12345678 @0x004, then read word @0x004 → MOC rises exactly 3 edges after MOV sampled; DataOut=0x12345678.
- Read byte @0x005, SignExt=0 → 0x00000034. Write byte 0x80 @0x006, read byte SignExt=1 → 0xFFFFFF80. Read half @0x006, SignExt=0 → 0x00008078.
- Wrap: write word 0xAABBCCDD @Address 0x000001FC with ADDR_W=9 and upper bits 0xFFFFF… set → read @0x1FC returns 0xAABBCCDD.
- Handshake: hold MOV high 5 cycles in ACK → MOC stays 1, no second access. Drop MOV → MOC=0 next edge. Pulse reset mid-WAIT of a write → target bytes unchanged.
- MISALIGN_TRAP_EN defined: word read @0x002 → MOC with AddrErr=1, DataOut=0. Undefined: same read returns the word @0x000.
